// File: rtl/wishbone_ctrl_stream_pkg.sv
// wishbone_ctrl_stream_pkg -- shared types and constants for the byte-stream
// to Wishbone bridge.
//   state_e        : command parser / bus sequencer states
//   REPLY_*        : fixed reply bytes returned on the tx stream
//   word_byte()    : selects one byte lane of a (zero-extended) bus word
package wishbone_ctrl_stream_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_ADDR,
      ST_WDATA,
      ST_WAIT,
      ST_RDATA
   } state_e;

   localparam logic [7:0] REPLY_IDLE    = 8'h00;  // idle / busy / filler
   localparam logic [7:0] REPLY_ACK     = 8'hFF;  // word acknowledged
   localparam logic [7:0] REPLY_TIMEOUT = 8'hEE;  // bus cycle abandoned

   function automatic logic [7:0] word_byte(input logic [31:0] word,
                                            input logic [1:0]  idx);
      return word[8*idx +: 8];
   endfunction

endpackage

// File: rtl/wishbone_ctrl_stream_timeout.sv
// wishbone_ctrl_stream_timeout -- ack wait watchdog.
// Counts the cycles wb_stb has been high; the count restarts on every rising
// edge of stb and expire_o pulses on the TIMEOUT_CYCLES-th cycle of a strobe.
// Only present when WISHBONE_CTRL_STREAM_TIMEOUT_EN is defined.
// Ports:
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   stb_i    : Wishbone strobe being watched
//   expire_o : single-cycle pulse, ack did not arrive in time
`ifdef WISHBONE_CTRL_STREAM_TIMEOUT_EN
module wishbone_ctrl_stream_timeout #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic stb_i,
   output logic expire_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d, cur;
   logic          stb_q;
   logic          rise;

   assign rise     = stb_i & ~stb_q;
   // on the rising cycle the stale count of the previous strobe is ignored
   assign cur      = rise ? '0 : cnt_q;
   assign expire_o = stb_i && (cur == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (stb_i && (cur != CW'(TIMEOUT_CYCLES))) cnt_d = cur + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         stb_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         stb_q <= stb_i;
      end
   end
endmodule
`endif

// File: rtl/wishbone_ctrl_stream.sv
// wishbone_ctrl_stream -- byte-stream command interface driving a Wishbone
// master. Every received byte yields exactly one reply byte one cycle later.
// Frame: header {WE, INC, 2'b00, SEL[3:0]}, count N (N+1 words), ADR_BYTES
// address bytes MSB first, then write data (LSB first) or dummy bytes that
// clock out read data (0xFF marks the ack, then data bytes LSB first).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_data, rx_stb       : received byte and its one-cycle strobe
//   tx_data, tx_stb       : reply byte and its one-cycle strobe
//   wb_cyc .. wb_ack      : Wishbone master port
// Build option: WISHBONE_CTRL_STREAM_TIMEOUT_EN bounds the ack wait to
// TIMEOUT_CYCLES; without it the wait is unbounded and no timer exists.
module wishbone_ctrl_stream
   import wishbone_ctrl_stream_pkg::*;
#(
   parameter int DATA_BYTES     = 4,
   parameter int ADR_BYTES      = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              rx_data,
   input  logic                    rx_stb,
   output logic [7:0]              tx_data,
   output logic                    tx_stb,
   output logic                    wb_cyc,
   output logic                    wb_stb,
   output logic                    wb_we,
   output logic [DATA_BYTES-1:0]   wb_sel,
   output logic [8*ADR_BYTES-1:0]  wb_adr,
   output logic [8*DATA_BYTES-1:0] wb_dat_o,
   input  logic [8*DATA_BYTES-1:0] wb_dat_i,
   input  logic                    wb_ack
);
   localparam int         AW        = 8 * ADR_BYTES;
   localparam int         DW        = 8 * DATA_BYTES;
   localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES - 1);
   localparam logic       LAST_ADR  = 1'(ADR_BYTES - 1);

   state_e                state_q, state_d;
   logic [7:0]            tx_data_q, tx_data_d, reply;
   logic                  tx_stb_q;
   logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, inc_q, inc_d;
   logic [DATA_BYTES-1:0] sel_q, sel_d;
   logic [AW-1:0]         adr_q, adr_d;
   logic [DW-1:0]         dat_q, dat_d, rdat_q, rdat_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [1:0]            bidx_q, bidx_d;
   logic                  abyte_q, abyte_d;
   logic                  ack_q, ack_d, to_q, to_d;
   logic                  expire, last_byte, last_adr, last_word;

`ifdef WISHBONE_CTRL_STREAM_TIMEOUT_EN
   wishbone_ctrl_stream_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .stb_i   (stb_q),
      .expire_o(expire)
   );
`else
   // never fires; the limit only matters when the timer is built
   assign expire = (TIMEOUT_CYCLES < 0);
`endif

   assign last_byte = (bidx_q == LAST_BYTE);
   assign last_adr  = (abyte_q == LAST_ADR);
   assign last_word = (cnt_q == 8'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (rx_stb) begin
         case (state_q)
            ST_IDLE:  if (rx_data != 8'h00) state_d = ST_COUNT;
            ST_COUNT: state_d = ST_ADDR;
            ST_ADDR:  if (last_adr) begin
                         if (we_q) state_d = ST_WDATA;
                         else      state_d = ST_WAIT;
                      end
            ST_WDATA: if (last_byte) state_d = ST_WAIT;
            ST_WAIT:  if (ack_q) begin
                         if (!we_q)         state_d = ST_RDATA;
                         else if (last_word) state_d = ST_IDLE;
                         else               state_d = ST_WDATA;
                      end else if (to_q) begin
                         state_d = ST_IDLE;
                      end
            ST_RDATA: if (last_byte) begin
                         if (last_word) state_d = ST_IDLE;
                         else           state_d = ST_WAIT;
                      end
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cyc_d   = cyc_q;   stb_d  = stb_q;  we_d   = we_q;   inc_d  = inc_q;
      sel_d   = sel_q;   adr_d  = adr_q;  dat_d  = dat_q;  rdat_d = rdat_q;
      cnt_d   = cnt_q;   bidx_d = bidx_q; abyte_d = abyte_q;
      ack_d   = ack_q;   to_d   = to_q;
      reply   = REPLY_IDLE;

      // Bus side runs independently of the rx stream; the ack is only
      // remembered here and reported on the next rx byte.
      if (stb_q && wb_ack) begin
         ack_d  = 1'b1;
         stb_d  = 1'b0;
         rdat_d = wb_dat_i;
      end else if (expire) begin
         stb_d = 1'b0;
         cyc_d = 1'b0;
         to_d  = 1'b1;
      end

      if (rx_stb) begin
         case (state_q)
            ST_IDLE: if (rx_data != 8'h00) begin
               we_d    = rx_data[7];
               inc_d   = rx_data[6];
               sel_d   = rx_data[DATA_BYTES-1:0];
               abyte_d = 1'b0;
            end
            ST_COUNT: cnt_d = rx_data;
            ST_ADDR: begin
               adr_d   = (adr_q << 8) | AW'(rx_data);
               abyte_d = abyte_q + 1'b1;
               bidx_d  = 2'd0;
               if (last_adr && !we_q) begin
                  cyc_d = 1'b1;
                  stb_d = 1'b1;
               end
            end
            ST_WDATA: begin
               dat_d[8*bidx_q +: 8] = rx_data;
               bidx_d = bidx_q + 2'd1;
               if (last_byte) begin
                  bidx_d = 2'd0;
                  cyc_d  = 1'b1;
                  stb_d  = 1'b1;
               end
            end
            ST_WAIT: if (ack_q) begin
               reply  = REPLY_ACK;
               ack_d  = 1'b0;
               bidx_d = 2'd0;
               if (we_q) begin
                  if (last_word) begin
                     cyc_d = 1'b0;
                  end else begin
                     cnt_d = cnt_q - 8'd1;
                     if (inc_q) adr_d = adr_q + AW'(1);
                  end
               end
            end else if (to_q) begin
               reply = REPLY_TIMEOUT;
               to_d  = 1'b0;
            end
            ST_RDATA: begin
               reply  = word_byte(32'(rdat_q), bidx_q);
               bidx_d = bidx_q + 2'd1;
               if (last_byte) begin
                  bidx_d = 2'd0;
                  if (last_word) begin
                     cyc_d = 1'b0;
                  end else begin
                     cnt_d = cnt_q - 8'd1;
                     if (inc_q) adr_d = adr_q + AW'(1);
                     stb_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      tx_data_d = rx_stb ? reply : tx_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_data_q <= '0;  tx_stb_q <= 1'b0;
         cyc_q     <= 1'b0; stb_q   <= 1'b0; we_q   <= 1'b0; inc_q <= 1'b0;
         sel_q     <= '0;  adr_q    <= '0;   dat_q  <= '0;   rdat_q <= '0;
         cnt_q     <= '0;  bidx_q   <= '0;   abyte_q <= 1'b0;
         ack_q     <= 1'b0; to_q    <= 1'b0;
      end else begin
         tx_data_q <= tx_data_d; tx_stb_q <= rx_stb;
         cyc_q     <= cyc_d;  stb_q  <= stb_d;  we_q   <= we_d;   inc_q <= inc_d;
         sel_q     <= sel_d;  adr_q  <= adr_d;  dat_q  <= dat_d;  rdat_q <= rdat_d;
         cnt_q     <= cnt_d;  bidx_q <= bidx_d; abyte_q <= abyte_d;
         ack_q     <= ack_d;  to_q   <= to_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_stb   = tx_stb_q;
   assign wb_cyc   = cyc_q;
   assign wb_stb   = stb_q;
   assign wb_we    = we_q;
   assign wb_sel   = sel_q;
   assign wb_adr   = adr_q;
   assign wb_dat_o = dat_q;
endmodule
